// File: rtl/h14tx_pkg.sv
// h14tx_pkg: shared TMDS period encoding for the HDMI 1.4 transmitter.
package h14tx_pkg;
    typedef enum logic [2:0] {
        Control,
        VideoPreamble,
        VideoGuard,
        VideoActive,
        DataIslandPreamble,
        DataIslandGuard,
        DataIslandActive
    } period_t;
endpackage

// File: rtl/h14tx_island_scheduler_if.sv
// h14tx_island_scheduler_if: raster/packet inputs and period outputs of the island scheduler.
interface h14tx_island_scheduler_if #(
    parameter int BitWidth  = 11,
    parameter int BitHeight = 10
);
    import h14tx_pkg::*;
    logic [BitWidth-1:0]  x;
    logic [BitHeight-1:0] y;
    period_t              video_period;
    logic                 pkt_valid;
    logic                 pkt_ready;
    period_t              period;
    logic [4:0]           word_idx;
    logic                 island;
    modport master (output x, y, video_period, pkt_valid, input pkt_ready, period, word_idx, island);
    modport slave  (input x, y, video_period, pkt_valid, output pkt_ready, period, word_idx, island);
endinterface

// File: rtl/h14tx_island_scheduler.sv
// h14tx_island_scheduler: places data islands in control slots of the raster.
// H14TX_ISLAND_VBLANK_EN lets islands start at x>=4 on vertical-blanking rows.
module h14tx_island_scheduler
    import h14tx_pkg::*;
#(
    parameter int BitWidth    = 11,
    parameter int BitHeight   = 10,
    parameter int FrameWidth  = 1650,
    parameter int ActiveWidth = 1280,
    parameter int MaxPackets  = 18
) (
    input logic                     clk,
    input logic                     rst_n,
    h14tx_island_scheduler_if.slave sched_io
);
    localparam logic [2:0] S_IDLE = 3'd0, S_PRE = 3'd1, S_LGUARD = 3'd2,
                           S_PKT = 3'd3, S_TGUARD = 3'd4, S_GAP = 3'd5;
    localparam int XW = BitWidth + 1;
    localparam logic [XW-1:0] LIMIT    = XW'(FrameWidth - 12);
    localparam logic [XW-1:0] HB_START = XW'(ActiveWidth + 4);
    localparam logic [XW-1:0] LEN1     = XW'(44);
    localparam logic [XW-1:0] NEXT_PKT = XW'(35);

    logic [2:0]    st_q, st_d, cur;
    logic [4:0]    ph_q, ph_d, cnt_q, cnt_d, wi_q, wi_d;
    period_t       period_q, period_d;
    logic          rdy_q, rdy_d, isl_q, isl_d;
    logic [XW-1:0] xe;
    logic          is_ctrl, thr_ok, start, in_isl, abort, last, more;

    assign xe      = {1'b0, sched_io.x};
    assign is_ctrl = sched_io.video_period == Control;

`ifdef H14TX_ISLAND_VBLANK_EN
    // Active height is learned from rows carrying video; a row is blank only while all-Control so far.
    logic                 row_ctrl_q, row_ctrl_d, row_ok, ctrl_so_far;
    logic [BitHeight-1:0] act_h_q, act_h_d;
    always_comb begin
        row_ok      = (sched_io.x == '0) | row_ctrl_q;
        ctrl_so_far = row_ok & is_ctrl;
        row_ctrl_d  = (xe < XW'(ActiveWidth)) ? ctrl_so_far : row_ctrl_q;
        act_h_d     = (xe == XW'(ActiveWidth - 1) && !ctrl_so_far) ? sched_io.y + 1'b1 : act_h_q;
        thr_ok      = (row_ok && sched_io.y >= act_h_q) ? xe >= XW'(4) : xe >= HB_START;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_ctrl_q <= 1'b0;
            act_h_q    <= '1;
        end else begin
            row_ctrl_q <= row_ctrl_d;
            act_h_q    <= act_h_d;
        end
    end
`else
    assign thr_ok = xe >= HB_START;
`endif

    // cur is the state that owns the current column; a start turns IDLE into PRE word 0 at once.
    always_comb begin
        start    = st_q == S_IDLE && is_ctrl && sched_io.pkt_valid && thr_ok && (xe + LEN1 <= LIMIT);
        cur      = start ? S_PRE : st_q;
        in_isl   = cur == S_PRE || cur == S_LGUARD || cur == S_PKT || cur == S_TGUARD;
        abort    = in_isl && !is_ctrl;
        last     = ph_q == (cur == S_PRE ? 5'd7 : cur == S_PKT ? 5'd31 : cur == S_GAP ? 5'd3 : 5'd1);
        more     = sched_io.pkt_valid && cnt_q < 5'(MaxPackets) && (xe + NEXT_PKT <= LIMIT);
        st_d     = abort ? S_IDLE :
                   (!last || cur == S_IDLE) ? cur :
                   cur == S_PRE ? S_LGUARD :
                   cur == S_LGUARD ? S_PKT :
                   cur == S_PKT ? (more ? S_PKT : S_TGUARD) :
                   cur == S_TGUARD ? S_GAP : S_IDLE;
        ph_d     = (abort || last || cur == S_IDLE) ? 5'd0 : ph_q + 5'd1;
        cnt_d    = (abort || cur == S_IDLE) ? 5'd0 : (cur == S_PKT && ph_q == 5'd0) ? cnt_q + 5'd1 : cnt_q;
        period_d = abort ? sched_io.video_period :
                   cur == S_PRE ? DataIslandPreamble :
                   (cur == S_LGUARD || cur == S_TGUARD) ? DataIslandGuard :
                   cur == S_PKT ? DataIslandActive : sched_io.video_period;
        rdy_d    = !abort && cur == S_PKT && ph_q == 5'd0;
        wi_d     = (!abort && cur == S_PKT) ? ph_q : 5'd0;
        isl_d    = in_isl && !abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= S_IDLE;
            ph_q     <= 5'd0;
            cnt_q    <= 5'd0;
            period_q <= Control;
            rdy_q    <= 1'b0;
            wi_q     <= 5'd0;
            isl_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            ph_q     <= ph_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            rdy_q    <= rdy_d;
            wi_q     <= wi_d;
            isl_q    <= isl_d;
        end
    end

    assign sched_io.period    = period_q;
    assign sched_io.pkt_ready = rdy_q;
    assign sched_io.word_idx  = wi_q;
    assign sched_io.island    = isl_q;
endmodule

// File: tb/tb_h14tx_island_scheduler.sv
// tb_h14tx_island_scheduler: directed raster lines with checkpoint tables and corner sequences.
module tb_h14tx_island_scheduler;
    import h14tx_pkg::*;

    typedef struct {
        int      ln;
        int      x;
        period_t p;
        bit      r;
        int      w;
        bit      i;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    h14tx_island_scheduler_if bus ();
    h14tx_island_scheduler dut (.clk(clk), .rst_n(rst_n), .sched_io(bus));

    period_t per [1650];
    bit      rdy [1650];
    int      wi  [1650];
    bit      isl [1650];
    int      pass_n = 0;
    int      tot_n  = 0;
    vec_t    tv[$];
    int      vf [5] = '{0, 0, 1400, 1595, 0};
    int      vt [5] = '{1649, 1649, 1400, 1649, 1649};
    int      rc [5] = '{10, 10, 1, 0, 10};

    task automatic chk(input string nm, input int got, input int exp);
        tot_n++;
        if (got == exp) pass_n++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic step(input int xx, input int yy, input period_t vp, input bit v);
        bus.x            = 11'(xx);
        bus.y            = 10'(yy);
        bus.video_period = vp;
        bus.pkt_valid    = v;
        @(posedge clk);
        #1;
        per[xx] = bus.period;
        rdy[xx] = bus.pkt_ready;
        wi[xx]  = int'(bus.word_idx);
        isl[xx] = bus.island;
    endtask

    task automatic line(input int yy, input bit act, input int vfrom, input int vto, input int x0, input int x1);
        for (int i = x0; i <= x1; i++)
            step(i, yy, (act && i < 1280) ? VideoActive : Control, i >= vfrom && i <= vto);
    endtask

    function automatic int n_rdy(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += int'(rdy[i]);
        return n;
    endfunction

    initial begin
        tv.push_back('{1, 0,    VideoActive,        0, 0,  0});
        tv.push_back('{1, 1283, Control,            0, 0,  0});
        tv.push_back('{1, 1284, DataIslandPreamble, 0, 0,  1});
        tv.push_back('{1, 1291, DataIslandPreamble, 0, 0,  1});
        tv.push_back('{1, 1292, DataIslandGuard,    0, 0,  1});
        tv.push_back('{1, 1293, DataIslandGuard,    0, 0,  1});
        tv.push_back('{1, 1294, DataIslandActive,   1, 0,  1});
        tv.push_back('{1, 1295, DataIslandActive,   0, 1,  1});
        tv.push_back('{1, 1325, DataIslandActive,   0, 31, 1});
        tv.push_back('{1, 1326, DataIslandActive,   1, 0,  1});
        tv.push_back('{1, 1582, DataIslandActive,   1, 0,  1});
        tv.push_back('{1, 1613, DataIslandActive,   0, 31, 1});
        tv.push_back('{1, 1614, DataIslandGuard,    0, 0,  1});
        tv.push_back('{1, 1615, DataIslandGuard,    0, 0,  1});
        tv.push_back('{1, 1616, Control,            0, 0,  0});
        tv.push_back('{2, 1283, Control,            0, 0,  0});
        tv.push_back('{2, 1284, DataIslandPreamble, 0, 0,  1});
        tv.push_back('{3, 1399, Control,            0, 0,  0});
        tv.push_back('{3, 1400, DataIslandPreamble, 0, 0,  1});
        tv.push_back('{3, 1409, DataIslandGuard,    0, 0,  1});
        tv.push_back('{3, 1410, DataIslandActive,   1, 0,  1});
        tv.push_back('{3, 1411, DataIslandActive,   0, 1,  1});
        tv.push_back('{3, 1441, DataIslandActive,   0, 31, 1});
        tv.push_back('{3, 1442, DataIslandGuard,    0, 0,  1});
        tv.push_back('{3, 1443, DataIslandGuard,    0, 0,  1});
        tv.push_back('{3, 1444, Control,            0, 0,  0});
        tv.push_back('{4, 1284, Control,            0, 0,  0});
        tv.push_back('{4, 1600, Control,            0, 0,  0});
        tv.push_back('{5, 1284, DataIslandPreamble, 0, 0,  1});

        rst_n            = 1'b0;
        bus.x            = '0;
        bus.y            = '0;
        bus.video_period = Control;
        bus.pkt_valid    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset period", int'(bus.period), int'(Control));
        chk("reset pkt_ready", int'(bus.pkt_ready), 0);
        chk("reset word_idx", int'(bus.word_idx), 0);
        chk("reset island", int'(bus.island), 0);
        rst_n = 1'b1;

        for (int ln = 1; ln <= 5; ln++) begin
            line(99 + ln, 1'b1, vf[ln-1], vt[ln-1], 0, 1649);
            foreach (tv[k]) if (tv[k].ln == ln) begin
                chk($sformatf("L%0d x%0d period", ln, tv[k].x), int'(per[tv[k].x]), int'(tv[k].p));
                chk($sformatf("L%0d x%0d pkt_ready", ln, tv[k].x), int'(rdy[tv[k].x]), int'(tv[k].r));
                chk($sformatf("L%0d x%0d word_idx", ln, tv[k].x), wi[tv[k].x], tv[k].w);
                chk($sformatf("L%0d x%0d island", ln, tv[k].x), int'(isl[tv[k].x]), int'(tv[k].i));
            end
            chk($sformatf("L%0d packet count", ln), n_rdy(0, 1649), rc[ln-1]);
        end

        // Reset while word 10 of the first packet is on the output.
        line(105, 1'b1, 0, 1649, 0, 1304);
        chk("pre-reset word_idx", wi[1304], 10);
        rst_n = 1'b0;
        #1;
        chk("async reset period", int'(bus.period), int'(Control));
        chk("async reset island", int'(bus.island), 0);
        chk("async reset pkt_ready", int'(bus.pkt_ready), 0);
        chk("async reset word_idx", int'(bus.word_idx), 0);
        #1;
        rst_n = 1'b1;
        line(105, 1'b1, 0, 1649, 1305, 1649);
        chk("post-reset period", int'(per[1305]), int'(DataIslandPreamble));
        chk("post-reset word_idx", wi[1305], 0);
        chk("post-reset early ready", n_rdy(1305, 1314), 0);
        chk("post-reset first ready", int'(rdy[1315]), 1);

        // Raster jumps back to column 0 in the middle of a packet.
        line(106, 1'b1, 0, 1649, 0, 1300);
        chk("pre-abort word_idx", wi[1300], 6);
        step(0, 107, VideoActive, 1'b1);
        chk("abort period", int'(per[0]), int'(VideoActive));
        chk("abort island", int'(isl[0]), 0);
        chk("abort pkt_ready", int'(rdy[0]), 0);
        chk("abort word_idx", wi[0], 0);
        line(107, 1'b1, 0, 1649, 1, 1649);
        chk("post-abort start", int'(per[1284]), int'(DataIslandPreamble));
        chk("post-abort packets", n_rdy(1280, 1649), 10);

        // One active row teaches the active height, then a blanking row.
        line(5, 1'b1, 2000, 0, 0, 1649);
        line(730, 1'b0, 0, 1649, 0, 1649);
`ifdef H14TX_ISLAND_VBLANK_EN
        chk("vblank x3 period", int'(per[3]), int'(Control));
        chk("vblank x4 period", int'(per[4]), int'(DataIslandPreamble));
        chk("vblank first ready", int'(rdy[14]), 1);
        chk("vblank packets", n_rdy(0, 591), 18);
        chk("vblank end guard", int'(per[591]), int'(DataIslandGuard));
        chk("vblank end island", int'(isl[591]), 1);
        chk("vblank after island", int'(isl[592]), 0);
`else
        chk("vblank x4 period", int'(per[4]), int'(Control));
        chk("vblank x4 island", int'(isl[4]), 0);
        chk("vblank hblank start", int'(per[1284]), int'(DataIslandPreamble));
        chk("vblank packets", n_rdy(0, 1649), 10);
`endif

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
